// File: rtl/instr_encoder.sv
// RV32I instruction packer: fields + signed immediate -> 32-bit word with range
// checking, behind a two-stage valid/ready pipeline that tags each word with a byte address.
module instr_encoder #(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [D_WIDTH-1:0]    imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D_WIDTH-1:0]    instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [1:0]            err
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [2:0]         fmt;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [D_WIDTH-1:0] imm;
  } req_t;

  localparam logic [D_WIDTH-1:0] NOP = 32'h0000_0013;

  req_t                  w_req, r_req;
  logic                  r_s1_valid, r_s2_valid;
  logic [D_WIDTH-1:0]    r_instr, w_instr;
  logic [1:0]            r_err, w_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_s2_adv;
  logic signed [31:0]    w_simm;

  assign w_req = '{fmt: fmt, opcode: opcode, funct3: funct3, funct7: funct7,
                   rd: rd, rs1: rs1, rs2: rs2, imm: imm};

  // s1 may refill in the same cycle s2 drains, so in_ready looks through to out_ready
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign out_valid = r_s2_valid;
  assign instr     = r_instr;
  assign err       = r_err;
  assign out_addr  = r_addr;
  assign w_simm    = $signed(r_req.imm);

  always_comb begin
    w_instr = NOP;
    w_err   = 2'b00;
    case (r_req.fmt)
      FMT_R: w_instr = {r_req.funct7, r_req.rs2, r_req.rs1, r_req.funct3, r_req.rd, r_req.opcode};
      FMT_I: begin
        w_instr  = {r_req.imm[11:0], r_req.rs1, r_req.funct3, r_req.rd, r_req.opcode};
        w_err[0] = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      end
      FMT_S: begin
        w_instr  = {r_req.imm[11:5], r_req.rs2, r_req.rs1, r_req.funct3,
                    r_req.imm[4:0], r_req.opcode};
        w_err[0] = (w_simm < -32'sd2048) || (w_simm > 32'sd2047);
      end
      FMT_B: begin
        w_instr  = {r_req.imm[12], r_req.imm[10:5], r_req.rs2, r_req.rs1, r_req.funct3,
                    r_req.imm[4:1], r_req.imm[11], r_req.opcode};
        w_err[0] = (w_simm < -32'sd4096) || (w_simm > 32'sd4094) || r_req.imm[0];
      end
      FMT_U: begin
        w_instr  = {r_req.imm[31:12], r_req.rd, r_req.opcode};
        w_err[0] = |r_req.imm[11:0];
      end
      FMT_J: begin
        w_instr  = {r_req.imm[20], r_req.imm[10:1], r_req.imm[11], r_req.imm[19:12],
                    r_req.rd, r_req.opcode};
        w_err[0] = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574) || r_req.imm[0];
      end
      default: begin
        w_instr = NOP;
        w_err   = 2'b10;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_req      <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_req <= w_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_err      <= 2'b00;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr <= w_instr;
        r_err   <= w_err;
      end
    end
  end

  // Address belongs to the word on the output; it moves only when that word leaves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_addr <= '0;
    else if (r_s2_valid && out_ready) r_addr <= r_addr + ADDR_WIDTH'(4);
  end

endmodule
